seq_averager: RTL
=================

SEQ_AVERAGER -- requirements
Module: seq_averager

Interface
REQ-001 SHALL have parameter WIDTH, default 6, meaning sample and result width in bits, signed two's complement, legal range 2..16.
REQ-002 SHALL have parameter N, default 9, meaning samples per average, legal range 2..32.
REQ-003 SHALL have parameter SLIDE, default 0, meaning 0 = block mode (non-overlapping windows) and 1 = sliding window.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port flush  input  1  synchronous clear of window contents and any pending result.
REQ-007 SHALL have port in_valid  input  1  in_data holds a sample.
REQ-008 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  signed sample.
REQ-010 SHALL have port out_valid  output  1  out_data holds a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  signed rounded average.

Function
REQ-013 SHALL accept a sample only on a rising edge with in_valid=1 and in_ready=1.
REQ-014 SHALL drive in_ready=1 only in state COLLECT with flush=0; in_ready SHALL be combinational from state and flush only.
REQ-015 SHALL implement the states COLLECT, DIV and OUT: COLLECT->DIV on the accept that completes a window; DIV->OUT after WIDTH iterations; OUT->COLLECT on out_valid & out_ready.
REQ-016 SHALL keep a sign-extended running sum of width WIDTH+clog2(N) that never overflows.
REQ-017 In block mode, SHALL clear the sum and sample count when DIV is entered; a window is complete on every N-th accepted sample.
REQ-018 In sliding mode, SHALL keep the last N samples in a circular buffer of depth N; each accept adds the new sample and subtracts the evicted one; the window is complete on every accept once N samples are held, starting with the N-th.
REQ-019 SHALL compute out_data = floor((2*S + N) / (2*N)) exactly, where S is the window sum: round-half-up toward +infinity, no approximation.
REQ-020 SHALL perform the division with a restoring divider at 1 quotient bit per clock: load numerator 2*S + N + 2*N*2^(WIDTH-1) as unsigned, divide by 2*N, then subtract 2^(WIDTH-1) from the quotient.
REQ-021 SHALL assert out_valid exactly WIDTH+1 rising edges after the accept that completes a window.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL hold no result when out_valid=0, and out_data SHALL then be 0.
REQ-024 When flush=1, SHALL on that edge clear the sum, count, buffer pointer and sample buffer, abort any division, drop out_valid, and go to COLLECT.
REQ-025 When flush=1 together with in_valid=1, SHALL drop the sample; when flush=1 together with an output handshake, flush SHALL win.
REQ-026 SHALL never produce out_data outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]; the average of in-range samples SHALL be in range by construction.

Reset
REQ-027 While rst_n=0, SHALL immediately force state=COLLECT, in_ready=1, out_valid=0, out_data=0, and sum, count, pointer, buffer and divider registers to 0.
REQ-028 On reset asserted mid-division or mid-handshake, SHALL discard the pending result with no partial output.
REQ-029 SHALL resume accepting samples on the first rising edge after rst_n deasserts.

Verification
REQ-030 Bench SHALL run defaults (WIDTH=6, N=9, SLIDE=0): samples 1..9 back-to-back -> out_data=5, out_valid high 7 edges after the 9th accept; in_ready=0 from DIV until the handshake.
REQ-031 Bench SHALL check rounding with defaults: eight 0 and one 5 -> 1; eight 0 and one 4 -> 0; eight 0 and one -5 -> -1; nine -32 -> -32; nine 31 -> 31.
REQ-032 Bench SHALL check ties with N=4: samples 1,1,0,0 -> 1; samples -1,-1,0,0 -> 0.
REQ-033 Bench SHALL run SLIDE=1, N=9, with samples 1..10 and an immediate out_ready -> two results, 5 then 6; no output before the 9th sample.
REQ-034 Bench SHALL hold out_ready=0 for 5 cycles -> out_data held, in_ready=0; then flush during DIV of the next window -> out_valid never rises, count restarts at 0.
REQ-035 Bench SHALL pulse rst_n low asynchronously mid-DIV -> outputs at reset values immediately, and the next 9 samples 2,2,2,2,2,2,2,2,2 -> 2.

Source files
------------

// File: rtl/seq_averager.sv
// Signed N-sample averager with round-half-up, block or sliding window, and a
// 1-bit-per-clock restoring divider that produces the exact rounded mean.
//   state   | meaning
//   COLLECT | accepting samples into the window
//   DIV     | WIDTH restoring-divide iterations, then result latch
//   OUT     | result presented until out_ready
module seq_averager #(
  parameter int WIDTH = 6,
  parameter int N     = 9,
  parameter int SLIDE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data
);
  localparam int SW = WIDTH + $clog2(N);
  localparam int DW = SW + 3;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(WIDTH + 1);
  // 2*N*2^(WIDTH-1): top divisor alignment and also the offset that makes the numerator non-negative
  localparam logic [DW-1:0] DSH0  = DW'(2 * N * (2 ** (WIDTH - 1)));
  localparam logic [DW-1:0] NUM_K = DW'(N + 2 * N * (2 ** (WIDTH - 1)));

  typedef enum logic [1:0] {COLLECT, DIV, OUT} state_t;

  state_t                  state_q, state_d;
  logic signed [SW-1:0]    sum_q, sum_d, sum_nxt, in_ext, ev_ext;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           rem_q, rem_d, dsh_q, dsh_d, num;
  logic [WIDTH-1:0]        quo_q, quo_d;
  logic [IW-1:0]           iter_q, iter_d;
  logic signed [WIDTH-1:0] res_q, res_d, evict;
  logic                    acc, win_done;

  assign in_ready  = (state_q == COLLECT) && !flush;
  assign acc       = in_valid && in_ready;
  assign win_done  = acc && (cnt_q >= CW'(N - 1));
  assign out_valid = (state_q == OUT);
  assign out_data  = res_q;

  assign in_ext  = {{(SW-WIDTH){in_data[WIDTH-1]}}, in_data};
  assign ev_ext  = {{(SW-WIDTH){evict[WIDTH-1]}}, evict};
  assign sum_nxt = sum_q + in_ext - ev_ext;
  assign num     = {{(DW-SW-1){sum_nxt[SW-1]}}, sum_nxt, 1'b0} + NUM_K;

  if (SLIDE != 0) begin : g_slide
    localparam int PW = $clog2(N);
    logic signed [WIDTH-1:0] win_q [N];
    logic [PW-1:0]           ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr_q <= '0;
        for (int i = 0; i < N; i++) win_q[i] <= '0;
      end else if (flush) begin
        ptr_q <= '0;
        for (int i = 0; i < N; i++) win_q[i] <= '0;
      end else if (acc) begin
        win_q[ptr_q] <= in_data;
        ptr_q        <= (ptr_q == PW'(N - 1)) ? '0 : ptr_q + 1'b1;
      end
    end

    // cleared slots read as zero, so eviction is harmless before the window fills
    assign evict = win_q[ptr_q];
  end else begin : g_block
    assign evict = '0;
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dsh_d   = dsh_q;
    quo_d   = quo_q;
    iter_d  = iter_q;
    res_d   = res_q;
    if (flush) begin
      state_d = COLLECT;
      sum_d   = '0;
      cnt_d   = '0;
      rem_d   = '0;
      dsh_d   = '0;
      quo_d   = '0;
      iter_d  = '0;
      res_d   = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (acc) begin
            if (SLIDE != 0) begin
              sum_d = sum_nxt;
              if (cnt_q != CW'(N)) cnt_d = cnt_q + 1'b1;
            end else begin
              sum_d = win_done ? '0 : sum_nxt;
              cnt_d = win_done ? '0 : cnt_q + 1'b1;
            end
            if (win_done) begin
              state_d = DIV;
              rem_d   = num;
              dsh_d   = DSH0;
              quo_d   = '0;
              iter_d  = IW'(WIDTH);
            end
          end
        end
        DIV: begin
          if (iter_q != '0) begin
            if (rem_q >= dsh_q) begin
              rem_d = rem_q - dsh_q;
              quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            dsh_d  = dsh_q >> 1;
            iter_d = iter_q - 1'b1;
          end else begin
            // removing the 2^(WIDTH-1) bias is an MSB flip in WIDTH bits
            res_d   = {~quo_q[WIDTH-1], quo_q[WIDTH-2:0]};
            state_d = OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            res_d   = '0;
            state_d = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      sum_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      dsh_q   <= '0;
      quo_q   <= '0;
      iter_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dsh_q   <= dsh_d;
      quo_q   <= quo_d;
      iter_q  <= iter_d;
      res_q   <= res_d;
    end
  end

endmodule
